prefetch_read_responder: RTL and testbench

Memory-side responder for the prefetcher's outgoing read-request port: accepts address requests over a valid/ready handshake and returns one data beat per request, in order, after a fixed latency. Serves as the memory model on the master side of the prefetcher controller in block-level and subsystem benches. Also usable as a synthesizable stand-in for a slow backing store. Buffers up to 2^LOG_QUEUE_DEPTH outstanding requests, so controller back-pressure and outstanding-limit paths can be exercised.

---
 rtl/prefetch_read_responder_pkg.sv | 14 +
 rtl/prefetch_read_responder_queue.sv | 84 ++++++++
 rtl/prefetch_read_responder.sv | 79 +++++++
 tb/tb_prefetch_read_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_read_responder_pkg.sv
// Shared types and constants for the prefetcher read responder.
// respEntry_t holds one outstanding request: its address and the cycles left before it may answer.
package prefetcherPkg;

  localparam int LATENCY_BITS  = 8;
  localparam int MAX_ADDR_BITS = 64;
  localparam logic [63:0] DATA_SEED_DEFAULT = 64'hA5A5_0000_0000_5A5A;

  typedef struct packed {
    logic [MAX_ADDR_BITS-1:0] addr;
    logic [LATENCY_BITS-1:0]  remaining;
  } respEntry_t;

endpackage

// File: rtl/prefetch_read_responder_queue.sv
// respQueue: circular buffer of outstanding requests.
// Every occupied entry counts down its own latency, but only the head may be released.
module respQueue
  import prefetcherPkg::*;
#(
  parameter int ADDR_BITS       = 64,
  parameter int LOG_QUEUE_DEPTH = 3,
  parameter int LATENCY         = 4
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic                       i_en,
  input  logic                       i_push,
  input  logic [ADDR_BITS-1:0]       i_push_addr,
  input  logic                       i_pop,
  output logic                       o_head_valid,
  output logic [ADDR_BITS-1:0]       o_head_addr,
  output logic [LOG_QUEUE_DEPTH:0]   o_count
);

  localparam int DEPTH    = 1 << LOG_QUEUE_DEPTH;
  localparam int PTR_BITS = LOG_QUEUE_DEPTH;
  localparam int CNT_BITS = LOG_QUEUE_DEPTH + 1;
  localparam logic [LATENCY_BITS-1:0] INIT_REM = LATENCY_BITS'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("respQueue: LATENCY must be in 1..255");
    end
    if (ADDR_BITS > MAX_ADDR_BITS) begin : g_bad_addr_bits
      $error("respQueue: ADDR_BITS exceeds MAX_ADDR_BITS");
    end
  endgenerate

  respEntry_t          r_entry [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic [DEPTH-1:0]    w_occ;
  respEntry_t          w_head;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_BITS-1:0] w_slot_ofs;

      // A slot is live when its distance from the read pointer is below the fill level.
      assign w_slot_ofs = PTR_BITS'(gi) - r_rd_ptr;
      assign w_occ[gi]  = CNT_BITS'(w_slot_ofs) < r_count;

      always_ff @(posedge clk) begin
        if (i_reset) begin
          r_entry[gi] <= '0;
        end else if (i_push && (r_wr_ptr == PTR_BITS'(gi))) begin
          r_entry[gi].addr      <= MAX_ADDR_BITS'(i_push_addr);
          r_entry[gi].remaining <= INIT_REM;
        end else if (i_en && w_occ[gi] && (r_entry[gi].remaining != '0)) begin
          r_entry[gi].remaining <= r_entry[gi].remaining - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = r_entry[r_rd_ptr];
  assign o_head_valid = (r_count != '0) && (w_head.remaining == '0);
  assign o_head_addr  = ADDR_BITS'(w_head.addr);
  assign o_count      = r_count;

endmodule

// File: rtl/prefetch_read_responder.sv
// Memory-side responder: in-order, fixed-latency data beats for accepted address requests.
// Optional PREFETCH_RESP_ERR_EN adds BAR/LIMIT window checking with a respErr output.
module prefetch_read_responder
  import prefetcherPkg::*;
#(
  parameter int ADDR_BITS       = 64,
  parameter int DATA_BITS       = 64,
  parameter int LOG_QUEUE_DEPTH = 3,
  parameter int LATENCY         = 4,
  parameter logic [DATA_BITS-1:0] DATA_SEED = DATA_BITS'(DATA_SEED_DEFAULT)
`ifdef PREFETCH_RESP_ERR_EN
  ,
  parameter logic [ADDR_BITS-1:0] BAR   = '0,
  parameter logic [ADDR_BITS-1:0] LIMIT = '1
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     reqValid,
  input  logic [ADDR_BITS-1:0]     reqAddr,
  output logic                     reqReady,
  output logic                     respValid,
  output logic [ADDR_BITS-1:0]     respAddr,
  output logic [DATA_BITS-1:0]     respData,
  input  logic                     respReady,
`ifdef PREFETCH_RESP_ERR_EN
  output logic                     respErr,
`endif
  output logic [LOG_QUEUE_DEPTH:0] outstandingCnt
);

  localparam int DEPTH = 1 << LOG_QUEUE_DEPTH;
  localparam logic [LOG_QUEUE_DEPTH:0] FULL_CNT = (LOG_QUEUE_DEPTH + 1)'(DEPTH);

  logic                     w_push;
  logic                     w_pop;
  logic                     w_head_valid;
  logic [ADDR_BITS-1:0]     w_head_addr;
  logic [LOG_QUEUE_DEPTH:0] w_count;
  logic [DATA_BITS-1:0]     w_gen_data;
  logic                     w_err;

  // Ready looks only at the registered fill level, so a same-cycle pop never frees a slot early.
  assign reqReady = en && !reset && (w_count != FULL_CNT);
  assign w_push   = reqValid && reqReady;
  assign w_pop    = w_head_valid && respReady;

  respQueue #(
    .ADDR_BITS      (ADDR_BITS),
    .LOG_QUEUE_DEPTH(LOG_QUEUE_DEPTH),
    .LATENCY        (LATENCY)
  ) u_queue (
    .clk         (clk),
    .i_reset     (reset),
    .i_en        (en),
    .i_push      (w_push),
    .i_push_addr (reqAddr),
    .i_pop       (w_pop),
    .o_head_valid(w_head_valid),
    .o_head_addr (w_head_addr),
    .o_count     (w_count)
  );

  assign w_gen_data = DATA_BITS'(w_head_addr) ^ DATA_SEED;

`ifdef PREFETCH_RESP_ERR_EN
  assign w_err   = w_head_valid && ((w_head_addr < BAR) || (w_head_addr > LIMIT));
  assign respErr = w_err;
`else
  assign w_err   = 1'b0;
`endif

  assign respValid      = w_head_valid;
  assign respAddr       = w_head_valid ? w_head_addr : '0;
  assign respData       = (w_head_valid && !w_err) ? w_gen_data : '0;
  assign outstandingCnt = w_count;

endmodule

// File: tb/tb_prefetch_read_responder.sv
// Directed bench for prefetch_read_responder: latency, back-pressure, stalls, en gating, reset flush.
module tb_prefetch_read_responder;

  localparam logic [63:0] SEED = 64'hA5A5_0000_0000_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        reqValid;
  logic [63:0] reqAddr;
  logic        reqReady;
  logic        respValid;
  logic [63:0] respAddr;
  logic [63:0] respData;
  logic        respReady;
  logic [3:0]  outstandingCnt;
`ifdef PREFETCH_RESP_ERR_EN
  logic        respErr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prefetch_read_responder #(
    .ADDR_BITS      (64),
    .DATA_BITS      (64),
    .LOG_QUEUE_DEPTH(3),
    .LATENCY        (4),
    .DATA_SEED      (SEED)
`ifdef PREFETCH_RESP_ERR_EN
    ,
    .BAR            (64'h100),
    .LIMIT          (64'h1FF)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .reqValid      (reqValid),
    .reqAddr       (reqAddr),
    .reqReady      (reqReady),
    .respValid     (respValid),
    .respAddr      (respAddr),
    .respData      (respData),
    .respReady     (respReady),
`ifdef PREFETCH_RESP_ERR_EN
    .respErr       (respErr),
`endif
    .outstandingCnt(outstandingCnt)
  );

  function automatic logic [63:0] exp_data(input logic [63:0] a);
`ifdef PREFETCH_RESP_ERR_EN
    if (a < 64'h100 || a > 64'h1FF) return 64'h0;
`endif
    return a ^ SEED;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [63:0] a);
    check({tag, "_valid"}, {63'd0, respValid}, 64'd1);
    check({tag, "_addr"}, respAddr, a);
    check({tag, "_data"}, respData, exp_data(a));
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_addr;

    reset = 1'b1; en = 1'b1; reqValid = 1'b0; reqAddr = '0; respReady = 1'b0;
    go(); #1;
    check("rst_reqReady", {63'd0, reqReady}, 64'd0);
    check("rst_respValid", {63'd0, respValid}, 64'd0);
    check("rst_respAddr", respAddr, 64'd0);
    check("rst_respData", respData, 64'd0);
    check("rst_cnt", {60'd0, outstandingCnt}, 64'd0);
    go(); reset = 1'b0; #1;
    check("post_rst_reqReady", {63'd0, reqReady}, 64'd1);
    $display("reset released: reqReady=%0b cnt=%0d", reqReady, outstandingCnt);

    // Single request: accepted at cycle t, beat visible at t+4 for one cycle.
    reqValid = 1'b1; reqAddr = 64'h1000; #1;
    check("single_accept", {63'd0, reqReady}, 64'd1);
    go(); reqValid = 1'b0; respReady = 1'b1; #1;
    check("single_wait1", {63'd0, respValid}, 64'd0);
    for (int k = 2; k < 4; k++) begin
      go(); #1;
      check("single_wait", {63'd0, respValid}, 64'd0);
    end
    go(); #1;
    check_beat("single", 64'h1000);
    check("single_data_abs", respData, 64'hA5A5_0000_0000_4A5A);
    $display("single beat: addr=%h data=%h", respAddr, respData);
    go(); #1;
    check("single_gone", {63'd0, respValid}, 64'd0);
    check("single_cnt", {60'd0, outstandingCnt}, 64'd0);

    // Back-to-back accepts return on consecutive cycles.
    reqValid = 1'b1; reqAddr = 64'h20;
    go(); reqAddr = 64'h28;
    go(); reqValid = 1'b0; #1;
    check("b2b_wait2", {63'd0, respValid}, 64'd0);
    go(); #1;
    check("b2b_wait3", {63'd0, respValid}, 64'd0);
    go(); #1;
    check_beat("b2b_first", 64'h20);
    go(); #1;
    check_beat("b2b_second", 64'h28);
    $display("b2b second beat: addr=%h", respAddr);
    go(); #1;
    check("b2b_done", {63'd0, respValid}, 64'd0);

    // Fill the queue with the consumer stalled.
    respReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reqValid = 1'b1; reqAddr = 64'h100 + 64'(8 * i); #1;
      check("fill_ready", {63'd0, reqReady}, 64'd1);
      go();
    end
    reqAddr = 64'h200; #1;
    check("full_reqReady", {63'd0, reqReady}, 64'd0);
    check("full_cnt", {60'd0, outstandingCnt}, 64'd8);
    $display("queue full: cnt=%0d reqReady=%0b", outstandingCnt, reqReady);
    go(); respReady = 1'b1; #1;
    check("full_hold", {63'd0, reqReady}, 64'd0);
    check_beat("full_pop", 64'h100);
    go(); respReady = 1'b0; #1;
    check("after_pop_ready", {63'd0, reqReady}, 64'd1);
    check("after_pop_cnt", {60'd0, outstandingCnt}, 64'd7);
    go(); reqValid = 1'b0; #1;
    check("refull_ready", {63'd0, reqReady}, 64'd0);
    check("refull_cnt", {60'd0, outstandingCnt}, 64'd8);

    // Drain with respReady high one cycle in three; beats must stay put while stalled.
    for (int i = 0; i < 8; i++) begin
      exp_addr = (i < 7) ? 64'h108 + 64'(8 * i) : 64'h200;
      for (int ph = 0; ph < 3; ph++) begin
        respReady = (ph == 2); #1;
        check_beat("drain", exp_addr);
        go();
      end
      $display("drain beat %0d: addr=%h", i, exp_addr);
    end
    respReady = 1'b0; #1;
    check("drain_empty_valid", {63'd0, respValid}, 64'd0);
    check("drain_empty_cnt", {60'd0, outstandingCnt}, 64'd0);

    // en low for 5 cycles right after the accept pushes the beat out by 5.
    reqValid = 1'b1; reqAddr = 64'h40; #1;
    check("en_accept", {63'd0, reqReady}, 64'd1);
    go(); reqValid = 1'b0; en = 1'b0; #1;
    check("en_low_ready", {63'd0, reqReady}, 64'd0);
    for (int c = 1; c < 9; c++) begin
      if (c > 1) go();
      en = (c >= 6); #1;
      check("en_wait", {63'd0, respValid}, 64'd0);
    end
    go(); #1;
    check_beat("en_beat", 64'h40);
    en = 1'b0;
    go(); #1;
    check_beat("en_hold", 64'h40);
    respReady = 1'b1;
    go(); respReady = 1'b0; en = 1'b1; #1;
    check("en_popped", {63'd0, respValid}, 64'd0);
    check("en_cnt", {60'd0, outstandingCnt}, 64'd0);
    $display("en gating: beat delayed to cycle 9, popped with en low");

    // Reset with three entries queued discards them all.
    for (int i = 0; i < 3; i++) begin
      reqValid = 1'b1; reqAddr = 64'h300 + 64'(8 * i);
      go();
    end
    reqValid = 1'b0;
    go(); #1;
    check_beat("pre_reset_head", 64'h300);
    reset = 1'b1;
    go(); reset = 1'b0; #1;
    check("flush_valid", {63'd0, respValid}, 64'd0);
    check("flush_cnt", {60'd0, outstandingCnt}, 64'd0);
    check("flush_addr", respAddr, 64'd0);
    for (int k = 0; k < 8; k++) begin
      go(); #1;
      check("no_stale", {63'd0, respValid}, 64'd0);
    end
    check("flush_ready", {63'd0, reqReady}, 64'd1);
    $display("reset flush: cnt=%0d respValid=%0b", outstandingCnt, respValid);

`ifdef PREFETCH_RESP_ERR_EN
    reqValid = 1'b1; reqAddr = 64'h200;
    go(); reqAddr = 64'h100;
    go(); reqValid = 1'b0; respReady = 1'b1; #1;
    go(); #1;
    go(); #1;
    check_beat("err_out", 64'h200);
    check("err_flag_out", {63'd0, respErr}, 64'd1);
    check("err_data_zero", respData, 64'd0);
    go(); #1;
    check_beat("err_in", 64'h100);
    check("err_flag_in", {63'd0, respErr}, 64'd0);
    go(); #1;
    check("err_idle", {63'd0, respErr}, 64'd0);
    respReady = 1'b0;
    $display("window check: 0x200 flagged, 0x100 clean");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
